// File: rtl/txrx_byte_fifo_pkg.sv
// ----------------------------------------------------------------------------
// txrx_byte_fifo_pkg
// Shared defaults for the TXRX byte path FIFO and its storage regfile.
//   TXRX_DATA_WIDTH : default word width of the byte path
//   TXRX_ADDR_WIDTH : default regfile address width (storage depth = 2**N)
// ----------------------------------------------------------------------------
package txrx_byte_fifo_pkg;

    localparam int TXRX_DATA_WIDTH = 8;
    localparam int TXRX_ADDR_WIDTH = 3;

endpackage : txrx_byte_fifo_pkg

// File: rtl/regf_dp_d0w_d1r.sv
// ----------------------------------------------------------------------------
// regf_dp_d0w_d1r
// Dual-port register file: port 0 is a synchronous write port, port 1 is a
// registered read port whose output holds its value while rd_1 is low.
// Ports:
//   clk        : clock, all state on posedge
//   rst        : asynchronous active-high reset (clears the read register only)
//   we_0       : write enable, port 0
//   address_0  : write address, port 0
//   data_0     : write data, port 0
//   rd_1       : read enable, port 1
//   address_1  : read address, port 1
//   data_1     : registered read data, port 1
// ----------------------------------------------------------------------------
module regf_dp_d0w_d1r
    import txrx_byte_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = TXRX_DATA_WIDTH,
    parameter int ADDR_WIDTH = TXRX_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] address_0,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic                  rd_1,
    input  logic [ADDR_WIDTH-1:0] address_1,
    output logic [DATA_WIDTH-1:0] data_1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_1_d;
    logic [DATA_WIDTH-1:0] data_1_q;

    // Storage array has no reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (we_0) begin
            mem[address_0] <= data_0;
        end
    end

    // Read register only loads on rd_1, so the output is stable while idle.
    always_comb begin
        data_1_d = data_1_q;
        if (rd_1) begin
            data_1_d = mem[address_1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_1_q <= '0;
        end else begin
            data_1_q <= data_1_d;
        end
    end

    assign data_1 = data_1_q;

endmodule : regf_dp_d0w_d1r

// File: rtl/txrx_byte_fifo.sv
// ----------------------------------------------------------------------------
// txrx_byte_fifo
// First-word-fall-through FIFO for the TXRX byte path. Storage lives in the
// dual-port regfile; this module owns the pointers, occupancy and handshakes
// and hides the regfile's one-cycle read latency behind a head-valid flag.
// Total capacity is DEPTH words in storage plus one word in the head register.
// Ports:
//   clk        : clock, all state on posedge
//   rst        : asynchronous active-high reset
//   flush      : synchronous clear of all contents, overrides push/pop
//   in_data    : write data
//   in_valid   : producer offers in_data
//   in_ready   : FIFO can accept (push = in_valid & in_ready)
//   out_data   : head word, forced to 0 while out_valid is low
//   out_valid  : head word present
//   out_ready  : consumer takes head (pop = out_valid & out_ready)
//   level      : words held, storage count plus head (0..DEPTH+1)
// ----------------------------------------------------------------------------
module txrx_byte_fifo
    import txrx_byte_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = TXRX_DATA_WIDTH,
    parameter int ADDR_WIDTH = TXRX_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level
);

    logic [ADDR_WIDTH:0]   wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH:0]   rd_ptr_d, rd_ptr_q;
    logic                  out_valid_d, out_valid_q;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  mem_full;
    logic                  mem_empty;
    logic                  push;
    logic                  pop;
    logic                  fetch;
    logic [DATA_WIDTH-1:0] rd_data;

    // Pointers carry an extra wrap bit: equal low bits with differing MSBs
    // means full, fully equal means empty. Both come from registered state
    // only, so a fetch can never target the slot being written this cycle.
    always_comb begin
        mem_cnt   = wr_ptr_q - rd_ptr_q;
        mem_empty = (wr_ptr_q == rd_ptr_q);
        mem_full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        in_ready  = ~mem_full & ~flush;
        push      = in_valid & in_ready;
        pop       = out_valid_q & out_ready;
        // Prefetch into the head register whenever it is empty or being
        // drained this cycle, which sustains one word per cycle.
        fetch     = ~mem_empty & (~out_valid_q | out_ready) & ~flush;
    end

    // Next-state: flush wins over everything; otherwise the head stays valid
    // if refilled by a fetch, and clears only on a pop with nothing behind it.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (fetch) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    regf_dp_d0w_d1r #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regf (
        .clk       (clk),
        .rst       (rst),
        .we_0      (push),
        .address_0 (wr_ptr_q[ADDR_WIDTH-1:0]),
        .data_0    (in_data),
        .rd_1      (fetch),
        .address_1 (rd_ptr_q[ADDR_WIDTH-1:0]),
        .data_1    (rd_data)
    );

    // Regfile output holds its last read, so mask it when the head is empty.
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_valid_q ? rd_data : '0;
        level     = mem_cnt + {{ADDR_WIDTH{1'b0}}, out_valid_q};
    end

endmodule : txrx_byte_fifo

// File: tb/tb_txrx_byte_fifo.sv
// ----------------------------------------------------------------------------
// tb_txrx_byte_fifo
// Self-checking bench for txrx_byte_fifo (DATA_WIDTH=8, ADDR_WIDTH=3).
// Inputs are driven just after the falling edge and outputs are sampled 1ns
// later, so each sample shows the state left by the previous rising edge.
// ----------------------------------------------------------------------------
module tb_txrx_byte_fifo;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] level;

    int checks;
    int failures;

    txrx_byte_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       fl;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [3:0] exp_lvl;
    } vec_t;

    localparam int NUM_VECS = 11;
    vec_t vecs [NUM_VECS];

    // Wait for the falling edge, drive inputs, then let outputs settle.
    task automatic applyStimulus(input logic iv, input logic [7:0] din,
                                 input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual,
                               input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int accepted;
        int received;
        int cycles;
        int max_level;
        logic [7:0] next_in;
        logic [7:0] exp_byte;
        logic [7:0] model_q [$];
        logic       iv_r;
        logic       or_r;

        checks   = 0;
        failures = 0;
        rst      = 1'b0;

        // Table rows: inputs for the cycle and outputs expected before its edge.
        //             iv    din    or    fl    ir    ov    od     lvl
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1};
        vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1};
        vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'd2};
        vecs[8]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 4'd3};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};

        // Reset then idle.
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);

        // Table-driven vectors.
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
            checkOutput($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_ir));
            checkOutput($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_ov));
            checkOutput($sformatf("vec%0d_out_data", i), int'(out_data), int'(vecs[i].exp_od));
            checkOutput($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].exp_lvl));
        end

        // Single push, head held stable while consumer stalls.
        doReset();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("single_not_yet_valid", int'(out_valid), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("single_hold%0d_data", i), int'(out_data), 8'hA5);
            checkOutput($sformatf("single_hold%0d_valid", i), int'(out_valid), 1);
            checkOutput($sformatf("single_hold%0d_level", i), int'(level), 1);
        end

        // Fill to DEPTH+1 with consumer stalled, then drain in order.
        doReset();
        accepted = 0;
        next_in  = 8'h01;
        cycles   = 0;
        while (accepted < 9 && cycles < 40) begin
            applyStimulus(1'b1, next_in, 1'b0, 1'b0);
            if (in_ready) begin
                accepted++;
                next_in++;
            end
            cycles++;
        end
        checkOutput("fill_accepted", accepted, 9);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("fill_in_ready", int'(in_ready), 0);
        checkOutput("fill_level", int'(level), 9);
        checkOutput("fill_head", int'(out_data), 8'h01);
        received = 0;
        exp_byte = 8'h01;
        cycles   = 0;
        while (received < 9 && cycles < 40) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (out_valid) begin
                checkOutput($sformatf("drain%0d", received), int'(out_data), int'(exp_byte));
                exp_byte++;
                received++;
            end
            cycles++;
        end
        checkOutput("drain_count", received, 9);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain_level", int'(level), 0);
        checkOutput("drain_out_valid", int'(out_valid), 0);

        // Streaming with both sides always ready across several wraps.
        doReset();
        accepted  = 0;
        received  = 0;
        max_level = 0;
        cycles    = 0;
        exp_byte  = 8'h00;
        while (received < 64 && cycles < 80) begin
            applyStimulus(accepted < 64, 8'(accepted), 1'b1, 1'b0);
            if (int'(level) > max_level) max_level = int'(level);
            if (out_valid) begin
                if (out_data !== exp_byte) begin
                    checkOutput($sformatf("stream_word%0d", received), int'(out_data), int'(exp_byte));
                end
                exp_byte++;
                received++;
            end
            if (in_valid && in_ready) accepted++;
            cycles++;
        end
        checkOutput("stream_received", received, 64);
        checkOutput("stream_cycles", cycles, 66);
        checkOutput("stream_level_le2", int'(max_level <= 2), 1);
        checkOutput("stream_last_word", int'(exp_byte), 8'h40);

        // Random handshakes against a queue scoreboard.
        doReset();
        model_q.delete();
        received = 0;
        cycles   = 0;
        while (received < 10000 && cycles < 60000) begin
            iv_r = 1'($urandom_range(0, 1));
            or_r = 1'($urandom_range(0, 1));
            applyStimulus(iv_r, 8'($urandom), or_r, 1'b0);
            if (int'(level) != model_q.size()) begin
                checkOutput("rand_level", int'(level), model_q.size());
            end
            if (out_valid && out_ready) begin
                if (model_q.size() == 0) begin
                    checkOutput("rand_pop_empty", 1, 0);
                end else begin
                    exp_byte = model_q.pop_front();
                    if (out_data !== exp_byte) begin
                        checkOutput("rand_data", int'(out_data), int'(exp_byte));
                    end
                end
                received++;
            end
            if (in_valid && in_ready) model_q.push_back(in_data);
            cycles++;
        end
        checkOutput("rand_received", received, 10000);

        // Flush with level 5 and a concurrent write offer.
        doReset();
        accepted = 0;
        cycles   = 0;
        while (accepted < 5 && cycles < 20) begin
            applyStimulus(1'b1, 8'(8'h50 + accepted), 1'b0, 1'b0);
            if (in_ready) accepted++;
            cycles++;
        end
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
        checkOutput("flush_pre_level", int'(level), 5);
        checkOutput("flush_in_ready", int'(in_ready), 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_level", int'(level), 0);
        checkOutput("flush_out_valid", int'(out_valid), 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_no_ghost_valid", int'(out_valid), 0);
        checkOutput("flush_no_ghost_level", int'(level), 0);

        // Asynchronous reset mid-stream, checked before the next rising edge.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("prereset_level", int'(level), 4);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_level", int'(level), 0);
        checkOutput("async_rst_out_valid", int'(out_valid), 0);
        checkOutput("async_rst_out_data", int'(out_data), 0);
        checkOutput("async_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_rst_out_valid", int'(out_valid), 0);
        checkOutput("post_rst_level", int'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_txrx_byte_fifo
